// File: rtl/mac_result_fifo_if.sv
// Result-side bundle of the MAC stage: issue-valid/result inputs and the FWFT drain handshake.
interface mac_result_fifo_if #(
    parameter int OUT_WIDTH = 17
);
    logic                 op_valid;
    logic [OUT_WIDTH-1:0] mac_data;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_ready;

    modport master (
        output op_valid, mac_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  op_valid, mac_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/mac_result_fifo.sv
// Aligns op_valid with the MAC stage result and captures results into a show-ahead FIFO.
// Optional MAC_FIFO_PEAK_EN adds a running maximum of accepted results on the peak port.
module mac_result_fifo #(
    parameter int OUT_WIDTH = 17,
    parameter int DEPTH     = 8,
    parameter int LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    mac_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef MAC_FIFO_PEAK_EN
    ,
    output logic [OUT_WIDTH-1:0]     peak
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [LATENCY-1:0]   vld_pipe;
    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 accept;
    logic                 drop;

    // Clearing the pipe on reset is what discards results still inside the MAC stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= bus.op_valid;
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign push   = vld_pipe[LATENCY-1];
    assign full   = (count == FULL_CNT);
    assign pop    = bus.out_valid & bus.out_ready;
    // A full FIFO still takes a result when the head leaves on the same edge.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= bus.mac_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifdef MAC_FIFO_PEAK_EN
    always_ff @(posedge clk) begin
        if (reset)
            peak <= '0;
        else if (accept && (bus.mac_data > peak))
            peak <= bus.mac_data;
    end
`endif

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = mem[rd_ptr];
endmodule

// File: tb/tb_mac_result_fifo.sv
// Drives a two-register A*B+C stage into mac_result_fifo; a timestamped queue model checks every cycle.
module tb_mac_result_fifo;
    localparam int W     = 17;
    localparam int DEPTH = 8;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_result_fifo_if #(.OUT_WIDTH(W)) bus();
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
`ifdef MAC_FIFO_PEAK_EN
    logic [W-1:0]           peak;
`endif

    mac_result_fifo #(.OUT_WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
`ifdef MAC_FIFO_PEAK_EN
        ,
        .peak     (peak)
`endif
    );

    // Upstream MAC stage: operands registered twice, result on the second register.
    logic [W-1:0] a_in, b_in, c_in, s1, s2;
    always_ff @(posedge clk) begin
        s1 <= W'(a_in * b_in + c_in);
        s2 <= s1;
    end
    assign bus.mac_data = s2;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int unsigned land_q[$];
    logic [W-1:0] mq[$];
    bit          m_ovf;
    logic [W-1:0] m_peak;
    bit          model_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: each issue lands LAT edges later; landing result queues unless full without a pop.
    always @(posedge clk) begin
        bit m_pop;
        bit m_push;
        int sz;
        if (reset) begin
            land_q.delete();
            mq.delete();
            m_ovf      = 1'b0;
            m_peak     = '0;
            model_live = 1'b1;
        end else if (model_live) begin
            sz     = mq.size();
            m_pop  = (sz != 0) && bus.out_ready;
            m_push = (land_q.size() != 0) && (land_q[0] == cyc);
            if (m_push) void'(land_q.pop_front());
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (sz < DEPTH || m_pop) begin
                    mq.push_back(bus.mac_data);
                    if (bus.mac_data > m_peak) m_peak = bus.mac_data;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (bus.op_valid) land_q.push_back(cyc + LAT);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("count", 32'(count), mq.size());
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
`ifdef MAC_FIFO_PEAK_EN
            chk("peak", 32'(peak), 32'(m_peak));
`endif
        end
    end

    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        bus.op_valid = v;
        if (v) begin
            a_in = a; b_in = b; c_in = c;
        end else begin
            a_in = W'($urandom); b_in = W'($urandom); c_in = W'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [W-1:0] val);
        step(1'b1, val, 17'd1, 17'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle(1);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bus.op_valid  = 1'b0;
        bus.out_ready = 1'b0;
        a_in = '0; b_in = '0; c_in = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
`ifdef MAC_FIFO_PEAK_EN
        chk("rst_peak", 32'(peak), 0);
`endif

        // Single result 5*8+2 = 42: visible three cycles after issue.
        step(1'b1, 17'd5, 17'd8, 17'd2);
        idle(1);
        chk("latency_not_yet", 32'(bus.out_valid), 0);
        idle(1);
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_data", 32'(bus.out_data), 42);
        chk("single_count", 32'(count), 1);
        bus.out_ready = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        chk("single_popped", 32'(count), 0);

        // Fill to DEPTH, then one more to overflow, then drain in order.
        for (int i = 1; i <= 8; i++) op(W'(i));
        idle(3);
        chk("fill_count", 32'(count), 8);
        chk("fill_no_ovf", 32'(overflow), 0);
        op(17'd9);
        idle(3);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_count", 32'(count), 8);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(bus.out_data), i);
            idle(1);
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", 32'(count), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Full with simultaneous push/pop across several pointer wraps.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            bus.out_ready = (i >= 10);
            op(W'(10 + i));
        end
        bus.op_valid = 1'b0;
        chk("stream_count", 32'(count), 8);
        chk("stream_no_ovf", 32'(overflow), 0);
        chk("stream_head", 32'(bus.out_data), 30);
        idle(12);
        chk("stream_drained", 32'(count), 0);

        // Reset while results are in flight and entries are stored.
        do_reset();
        op(17'd100);
        op(17'd101);
        idle(3);
        chk("pre_rst_count", 32'(count), 2);
        op(17'd102);
        op(17'd103);
        reset = 1'b1;
        step(1'b1, 17'd104, 17'd1, 17'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_count", 32'(count), 0);
            chk("midrst_valid", 32'(bus.out_valid), 0);
            chk("midrst_ovf", 32'(overflow), 0);
            idle(1);
        end

        // Running maximum ignores the dropped 1000.
        do_reset();
        op(17'd5);
        op(17'd300);
        op(17'd7);
        for (int i = 0; i < 5; i++) op(17'd2);
        op(17'd1000);
        idle(3);
        chk("peak_case_ovf", 32'(overflow), 1);
        chk("peak_case_count", 32'(count), 8);
`ifdef MAC_FIFO_PEAK_EN
        chk("peak_value", 32'(peak), 300);
        do_reset();
        chk("peak_reset", 32'(peak), 0);
`endif
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
